// File: rtl/crossbar_pkg.sv
// Shared types and helpers for the crossbar row-load controller.
// The one-hot helper is sized for the widest supported bank; callers
// size-cast the result down to their own NUM_ROWS.
package crossbar_pkg;

  // Controller phases: idle, streaming rows, firing execute, waiting, reporting.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    EXEC   = 3'd2,
    WAIT   = 3'd3,
    FINISH = 3'd4
  } xbar_ctrl_state_t;

  // Widest bank the helper can decode; NUM_ROWS must not exceed this.
  localparam int unsigned MAX_ROWS = 64;
  localparam int unsigned IDX_W    = 6;

  // One-hot row strobe for row index idx; all zeros if idx is out of range.
  function automatic logic [MAX_ROWS-1:0] onehot_row(input logic [IDX_W-1:0] idx);
    logic [MAX_ROWS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/xbar_row_sel.sv
// Row selector for the crossbar bank: tracks which row the next accepted
// beat belongs to and drives the registered shared data bus plus the
// registered one-hot load strobe. A strobe lasts exactly one cycle per beat.
module xbar_row_sel
  import crossbar_pkg::*;
#(
  parameter int N        = 10,
  parameter int NUM_ROWS = 8,
  parameter int ROW_W    = $clog2(NUM_ROWS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,       // restart row counting at row 0
  input  logic                beat,      // a row is accepted this cycle
  input  logic [N-1:0]        in_data,
  output logic [ROW_W-1:0]    row_idx,
  output logic [N-1:0]        xbar_data,
  output logic [NUM_ROWS-1:0] pim_load
);

  // Advance the row index on each beat and present that row on the bus with its strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx   <= '0;
      xbar_data <= '0;
      pim_load  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop here samples pre-edge values.
      pim_load <= '0;
      if (clr) begin
        row_idx <= '0;
      end else if (beat) begin
        row_idx   <= row_idx + ROW_W'(1);
        xbar_data <= in_data;
        pim_load  <= NUM_ROWS'(onehot_row(IDX_W'(row_idx)));
      end
    end
  end

endmodule

// File: rtl/crossbar_load_ctrl.sv
// Crossbar row-load sequencer. Accepts a job of cfg_rows rows over a
// valid/ready stream, loads them one per beat into the row register bank,
// fires a single execute pulse once the last row is captured, then waits
// for pim_done under a bounded timeout. abort returns to IDLE from anywhere
// without reporting; rows already loaded stay in the bank.
module crossbar_load_ctrl
  import crossbar_pkg::*;
#(
  parameter int N        = 10,
  parameter int NUM_ROWS = 8,
  parameter int TIMEOUT  = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [$clog2(NUM_ROWS+1)-1:0]    cfg_rows,
  input  logic                             abort,
  input  logic                             in_valid,
  input  logic [N-1:0]                     in_data,
  output logic                             in_ready,
  output logic [N-1:0]                     xbar_data,
  output logic [NUM_ROWS-1:0]              pim_load,
  output logic                             pim_exec,
  input  logic                             pim_done,
  output logic                             busy,
  output logic                             done,
  output logic                             err
);

  localparam int ROW_W = $clog2(NUM_ROWS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [ROW_W-1:0] ROWS_MAX = ROW_W'(NUM_ROWS);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};

  xbar_ctrl_state_t   state;
  logic [ROW_W-1:0]   rows_q;
  logic [ROW_W-1:0]   row_idx;
  logic [TMO_W-1:0]   tmo_cnt;

  logic               cfg_ok;
  logic               beat;
  logic               last_beat;
  logic               job_go;
  logic               row_clr;

  // A job must ask for at least one row and no more than the bank holds.
  assign cfg_ok    = (cfg_rows != '0) && (cfg_rows <= ROWS_MAX);

  // Rows are only taken while loading; abort overrides a coincident beat.
  assign in_ready  = (state == LOAD);
  assign beat      = in_ready && in_valid && !abort;
  assign last_beat = beat && (row_idx == rows_q - ROW_W'(1));

  assign job_go    = (state == IDLE) && start && cfg_ok && !abort;
  assign row_clr   = job_go || abort;

  xbar_row_sel #(
    .N        (N),
    .NUM_ROWS (NUM_ROWS),
    .ROW_W    (ROW_W)
  ) u_row_sel (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (row_clr),
    .beat      (beat),
    .in_data   (in_data),
    .row_idx   (row_idx),
    .xbar_data (xbar_data),
    .pim_load  (pim_load)
  );

  // Job sequencing, timeout counting and the registered status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rows_q   <= '0;
      tmo_cnt  <= '0;
      pim_exec <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // NOTE: pulses default low every edge so each one is exactly one cycle wide.
      pim_exec <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_ok) begin
                rows_q <= cfg_rows;
                busy   <= 1'b1;
                state  <= LOAD;
              end else begin
                err <= 1'b1;
              end
            end
          end

          LOAD: begin
            if (last_beat) state <= EXEC;
          end

          // Strobe for the last row is live this cycle, so the row is captured
          // at this edge and execute follows in the next cycle.
          EXEC: begin
            pim_exec <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAIT;
          end

          // Completion beats the timeout when both land in the same cycle.
          WAIT: begin
            if (pim_done) begin
              done  <= 1'b1;
              state <= FINISH;
            end else if (tmo_cnt == TMO_LAST) begin
              err   <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (tmo_cnt != TMO_MAX) begin
              tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
          end

          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crossbar_load_ctrl.sv
// Bench for crossbar_load_ctrl. Two instances share the stream inputs:
// u_dut0 uses the default 256-cycle timeout, u_dut1 a 4-cycle timeout; each
// has its own start. A job-level model predicts every output of both
// instances on every cycle, and directed literal checks pin the model.
module tb_crossbar_load_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start0, start1;
  logic [3:0] cfg_rows;
  logic       abort;
  logic       in_valid;
  logic [9:0] in_data;
  logic       pim_done;

  logic       ready0, busy0, exec0, done0, err0;
  logic [9:0] xbar0;
  logic [7:0] load0;
  logic       ready1, busy1, exec1, done1, err1;
  logic [9:0] xbar1;
  logic [7:0] load1;

  int checks = 0;
  int errors = 0;

  crossbar_load_ctrl #(.N(10), .NUM_ROWS(8), .TIMEOUT(256)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_rows(cfg_rows), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready0), .xbar_data(xbar0),
    .pim_load(load0), .pim_exec(exec0), .pim_done(pim_done), .busy(busy0),
    .done(done0), .err(err0)
  );

  crossbar_load_ctrl #(.N(10), .NUM_ROWS(8), .TIMEOUT(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .cfg_rows(cfg_rows), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(ready1), .xbar_data(xbar1),
    .pim_load(load1), .pim_exec(exec1), .pim_done(pim_done), .busy(busy1),
    .done(done1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Job-level view of one controller: what it is doing and what it last emitted.
  typedef struct packed {
    bit         active;     // a job is in progress
    bit         loading;    // still taking rows
    bit         exec_next;  // all rows in, execute fires next
    bit         waiting;    // execute sent, waiting for completion
    bit         finishing;  // completion seen, reporting
    int         rows_total;
    int         rows_got;
    int         wait_n;     // waiting cycles already spent without completion
    logic [9:0] xbar;
    logic [7:0] load;
    bit         exec;
    bit         done;
    bit         err;
  } mdl_t;

  mdl_t m0, m1;

  function automatic mdl_t mdl_step(input mdl_t c, input bit st, input int cfg,
                                    input bit ab, input bit iv, input logic [9:0] d,
                                    input bit pd, input int tmo);
    mdl_t n;
    n      = c;
    n.load = '0;
    n.exec = 1'b0;
    n.done = 1'b0;
    n.err  = 1'b0;
    if (ab) begin
      n.active    = 1'b0;
      n.loading   = 1'b0;
      n.exec_next = 1'b0;
      n.waiting   = 1'b0;
      n.finishing = 1'b0;
    end else if (!c.active) begin
      if (st) begin
        if (cfg >= 1 && cfg <= 8) begin
          n.active     = 1'b1;
          n.loading    = 1'b1;
          n.rows_total = cfg;
          n.rows_got   = 0;
        end else begin
          n.err = 1'b1;
        end
      end
    end else if (c.loading) begin
      if (iv) begin
        n.xbar     = d;
        n.load     = 8'(1 << c.rows_got);
        n.rows_got = c.rows_got + 1;
        if (n.rows_got == c.rows_total) begin
          n.loading   = 1'b0;
          n.exec_next = 1'b1;
        end
      end
    end else if (c.exec_next) begin
      n.exec_next = 1'b0;
      n.exec      = 1'b1;
      n.waiting   = 1'b1;
      n.wait_n    = 0;
    end else if (c.waiting) begin
      if (pd) begin
        n.waiting   = 1'b0;
        n.finishing = 1'b1;
        n.done      = 1'b1;
      end else if (c.wait_n == tmo - 1) begin
        n.waiting = 1'b0;
        n.active  = 1'b0;
        n.err     = 1'b1;
      end else begin
        n.wait_n = c.wait_n + 1;
      end
    end else if (c.finishing) begin
      n.finishing = 1'b0;
      n.active    = 1'b0;
    end
    return n;
  endfunction

  // Advance both models on the same edges and reset as the DUTs do.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mdl_step(m0, start0, int'(cfg_rows), abort, in_valid, in_data, pim_done, 256);
      m1 <= mdl_step(m1, start1, int'(cfg_rows), abort, in_valid, in_data, pim_done, 4);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input logic rdy, input logic bsy, input logic ex,
                     input logic dn, input logic er, input logic [9:0] x,
                     input logic [7:0] ld, input mdl_t mm);
    check({tag, "_in_ready"}, 32'(rdy), 32'(mm.loading));
    check({tag, "_busy"},     32'(bsy), 32'(mm.active));
    check({tag, "_pim_exec"}, 32'(ex),  32'(mm.exec));
    check({tag, "_done"},     32'(dn),  32'(mm.done));
    check({tag, "_err"},      32'(er),  32'(mm.err));
    check({tag, "_xbar"},     32'(x),   32'(mm.xbar));
    check({tag, "_pim_load"}, 32'(ld),  32'(mm.load));
  endtask

  // Every cycle, away from the active edge, both instances must match their model.
  always @(negedge clk) begin
    cmp("d0", ready0, busy0, exec0, done0, err0, xbar0, load0, m0);
    cmp("d1", ready1, busy1, exec1, done1, err1, xbar1, load1, m1);
  end

  // One clock edge, then settle just past the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  int load_cnt;
  int exec_cnt;

  initial begin
    rst_n    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    cfg_rows = '0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    pim_done = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    check("rst_busy",  32'(busy0),  32'h0);
    check("rst_ready", 32'(ready0), 32'h0);
    check("rst_load",  32'(load0),  32'h0);
    check("rst_xbar",  32'(xbar0),  32'h0);

    // Three-row job with completion five cycles after execute
    start0 = 1'b1; cfg_rows = 4'd3;
    tick();
    check("t2_busy_up",  32'(busy0),  32'h1);
    check("t2_ready_up", 32'(ready0), 32'h1);
    start0 = 1'b0; in_valid = 1'b1; in_data = 10'h001;
    tick();
    check("t2_load_r0", 32'(load0), 32'h01);
    check("t2_xbar_r0", 32'(xbar0), 32'h001);
    in_data = 10'h002;
    tick();
    check("t2_load_r1", 32'(load0), 32'h02);
    check("t2_xbar_r1", 32'(xbar0), 32'h002);
    in_data = 10'h3FF;
    tick();
    check("t2_load_r2",  32'(load0),  32'h04);
    check("t2_xbar_r2",  32'(xbar0),  32'h3FF);
    check("t2_ready_dn", 32'(ready0), 32'h0);
    check("t2_exec_early", 32'(exec0), 32'h0);
    in_valid = 1'b0;
    tick();
    check("t2_exec",      32'(exec0), 32'h1);
    check("t2_load_idle", 32'(load0), 32'h0);
    repeat (4) tick();
    check("t2_exec_once", 32'(exec0), 32'h0);
    pim_done = 1'b1;
    tick();
    check("t2_done",      32'(done0), 32'h1);
    check("t2_busy_fin",  32'(busy0), 32'h1);
    pim_done = 1'b0;
    tick();
    check("t2_done_end",  32'(done0), 32'h0);
    check("t2_busy_end",  32'(busy0), 32'h0);

    // Full bank with in_valid toggling: loads only on valid cycles, one execute
    load_cnt = 0;
    exec_cnt = 0;
    start0 = 1'b1; cfg_rows = 4'd8;
    tick();
    start0 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 10'(i * 37 + 5);
      tick();
      check("t3_load_gap", 32'(load0 != 8'h00), 32'((i % 2) == 0));
      if (load0 != 8'h00) load_cnt++;
      if (exec0) exec_cnt++;
    end
    in_valid = 1'b0;
    pim_done = 1'b1;
    tick();
    if (exec0) exec_cnt++;
    check("t3_done", 32'(done0), 32'h1);
    pim_done = 1'b0;
    tick();
    if (exec0) exec_cnt++;
    check("t3_load_cnt", 32'(load_cnt), 32'd8);
    check("t3_exec_cnt", 32'(exec_cnt), 32'd1);

    // Out-of-range row counts
    start0 = 1'b1; cfg_rows = 4'd0;
    tick();
    check("t4_err_zero",  32'(err0),  32'h1);
    check("t4_busy_zero", 32'(busy0), 32'h0);
    cfg_rows = 4'd9;
    tick();
    check("t4_err_nine",  32'(err0),  32'h1);
    check("t4_busy_nine", 32'(busy0), 32'h0);
    check("t4_load_nine", 32'(load0), 32'h0);
    start0 = 1'b0;
    tick();
    check("t4_err_clear", 32'(err0),  32'h0);

    // Short timeout: no completion -> err on the fourth cycle after WAIT entry
    start1 = 1'b1; cfg_rows = 4'd1;
    tick();
    start1 = 1'b0; in_valid = 1'b1; in_data = 10'h0A5;
    tick();
    check("t5_load", 32'(load1), 32'h01);
    in_valid = 1'b0;
    tick();
    check("t5_exec", 32'(exec1), 32'h1);
    repeat (3) tick();
    check("t5_err_early", 32'(err1),  32'h0);
    check("t5_busy_wait", 32'(busy1), 32'h1);
    tick();
    check("t5_err_tmo",   32'(err1),  32'h1);
    check("t5_done_tmo",  32'(done1), 32'h0);
    check("t5_busy_tmo",  32'(busy1), 32'h0);
    tick();
    // Completion arriving in the timeout cycle wins
    start1 = 1'b1;
    tick();
    start1 = 1'b0; in_valid = 1'b1; in_data = 10'h15A;
    tick();
    in_valid = 1'b0;
    tick();
    check("t5b_exec", 32'(exec1), 32'h1);
    repeat (3) tick();
    pim_done = 1'b1;
    tick();
    check("t5b_done", 32'(done1), 32'h1);
    check("t5b_err",  32'(err1),  32'h0);
    pim_done = 1'b0;
    tick();
    check("t5b_busy_end", 32'(busy1), 32'h0);
    check("t5b_err_end",  32'(err1),  32'h0);

    // Abort during LOAD after one beat, then a fresh job is accepted
    start0 = 1'b1; cfg_rows = 4'd4;
    tick();
    start0 = 1'b0; in_valid = 1'b1; in_data = 10'h111;
    tick();
    check("t6_load_r0", 32'(load0), 32'h01);
    abort = 1'b1; in_data = 10'h222;
    tick();
    check("t6_ab_busy",  32'(busy0),  32'h0);
    check("t6_ab_load",  32'(load0),  32'h0);
    check("t6_ab_ready", 32'(ready0), 32'h0);
    check("t6_ab_err",   32'(err0),   32'h0);
    check("t6_ab_xbar",  32'(xbar0),  32'h111);
    abort = 1'b0; in_valid = 1'b0;
    start0 = 1'b1; cfg_rows = 4'd2;
    tick();
    check("t6_restart", 32'(busy0), 32'h1);
    start0 = 1'b0; in_valid = 1'b1; in_data = 10'h333;
    tick();
    check("t6_re_load0", 32'(load0), 32'h01);
    in_data = 10'h044;
    tick();
    check("t6_re_load1", 32'(load0), 32'h02);
    in_valid = 1'b0;
    tick();
    pim_done = 1'b1;
    tick();
    check("t6_re_done", 32'(done0), 32'h1);
    pim_done = 1'b0;
    tick();

    // Abort during WAIT beats a coincident completion
    start0 = 1'b1; cfg_rows = 4'd1;
    tick();
    start0 = 1'b0; in_valid = 1'b1; in_data = 10'h3C3;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6w_exec", 32'(exec0), 32'h1);
    tick();
    abort = 1'b1; pim_done = 1'b1;
    tick();
    check("t6w_busy", 32'(busy0), 32'h0);
    check("t6w_done", 32'(done0), 32'h0);
    check("t6w_err",  32'(err0),  32'h0);
    abort = 1'b0; pim_done = 1'b0;
    tick();
    check("t6w_done_after", 32'(done0), 32'h0);
    // abort together with start in IDLE: stays idle
    abort = 1'b1; start0 = 1'b1; cfg_rows = 4'd2;
    tick();
    check("t6i_busy", 32'(busy0), 32'h0);
    check("t6i_err",  32'(err0),  32'h0);
    abort = 1'b0;
    tick();
    check("t6i_accept", 32'(busy0), 32'h1);
    start0 = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // Async reset mid-LOAD: everything drops at once
    start0 = 1'b1; cfg_rows = 4'd3;
    tick();
    start0 = 1'b0; in_valid = 1'b1; in_data = 10'h155;
    tick();
    in_data = 10'h2AA;
    tick();
    check("t1_load_r1", 32'(load0), 32'h02);
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("t1_busy",  32'(busy0),  32'h0);
    check("t1_load",  32'(load0),  32'h0);
    check("t1_ready", 32'(ready0), 32'h0);
    check("t1_xbar",  32'(xbar0),  32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_post_busy", 32'(busy0), 32'h0);
    check("t1_post_done", 32'(done0), 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
